// File: rtl/vid_pkg.sv
// Shared types and helpers for the CRTC-to-VRAM fetch address generator.
//   vid_amode_e  : VRAM addressing mode selected by the mode input
//   vid_state_e  : fetch FSM states
//   f_vid_offset : composes the 16-bit in-page byte offset of a character
package vid_pkg;

    localparam int unsigned MA_W  = 14;
    localparam int unsigned RA_W  = 5;
    localparam int unsigned OFF_W = 16;

    typedef enum logic [1:0] {
        AM_CPC    = 2'd0,
        AM_ALESTE = 2'd1,
        AM_LINEAR = 2'd2,
        AM_HIRES  = 2'd3
    } vid_amode_e;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_ISSUE = 1'b1
    } vid_state_e;

    // Only the low three row-address bits ever reach the offset.
    function automatic logic [OFF_W-1:0] f_vid_offset(
        input logic [MA_W-1:0] ma,
        input logic [2:0]      ra,
        input vid_amode_e      mode
    );
        logic [OFF_W-1:0] off;
        off = '0;
        case (mode)
            AM_CPC:    off = {ma[13:12], ra[2:0], ma[9:0], 1'b0};
            AM_ALESTE: off = {ra[0], ma[13:0], 1'b0};
            AM_LINEAR: off = {1'b0, ma[13:0], 1'b0};
            AM_HIRES:  off = {ra[1:0], ma[12:0], 1'b0};
            default:   off = {1'b0, ma[13:0], 1'b0};
        endcase
        return off;
    endfunction

endpackage

// File: rtl/vid_fetch_agen_if.sv
// VRAM arbiter read-request bus.
//   req  : read request            (master -> slave)
//   addr : byte address            (master -> slave)
//   idx  : beat index in character (master -> slave)
//   last : final beat of character (master -> slave)
//   ack  : beat accepted           (slave -> master)
interface vid_fetch_agen_if #(
    parameter int unsigned ADDR_W = 24,
    parameter int unsigned IDX_W  = 1
) ();

    logic              req;
    logic [ADDR_W-1:0] addr;
    logic [IDX_W-1:0]  idx;
    logic              last;
    logic              ack;

    modport master (output req, addr, idx, last, input ack);
    modport slave  (input req, addr, idx, last, output ack);

endinterface

// File: rtl/vid_fetch_q.sv
// Synchronous character queue, DEPTH entries of W bits.
//   clk, rst     : clock, synchronous active-high reset
//   flush        : empties the queue (wins over push/pop)
//   push, wdata  : write an entry; accepted when not full or when popping
//   pop          : drop the head entry
//   head_nxt_c   : head entry as it will be after this cycle's push/pop
//   empty_nxt_c  : queue will be empty after this cycle
//   full_c       : queue holds DEPTH entries
//   empty_c      : queue holds no entries
//   count        : number of entries held
module vid_fetch_q #(
    parameter int unsigned W     = 24,
    parameter int unsigned DEPTH = 2,
    parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic             pop,
    input  logic [W-1:0]     wdata,
    output logic [W-1:0]     head_nxt_c,
    output logic             empty_nxt_c,
    output logic             full_c,
    output logic             empty_c,
    output logic [CNT_W-1:0] count
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]     mem_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count_nxt;
    logic             push_ok;
    logic             pop_ok;

    function automatic logic [PTR_W-1:0] f_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign full_c  = (count == CNT_W'(DEPTH));
    assign empty_c = (count == '0);

    // A full queue still takes a write when its head leaves the same cycle.
    assign pop_ok  = pop & ~empty_c & ~flush;
    assign push_ok = push & (~full_c | pop_ok) & ~flush;

    // Next occupancy
    always_comb begin
        count_nxt = count;
        if (flush) begin
            count_nxt = '0;
        end else begin
            case ({push_ok, pop_ok})
                2'b10:   count_nxt = count + CNT_W'(1);
                2'b01:   count_nxt = count - CNT_W'(1);
                default: count_nxt = count;
            endcase
        end
    end

    assign empty_nxt_c = (count_nxt == '0);

    // Look-ahead head so the consumer can register its outputs
    always_comb begin
        head_nxt_c = wdata;
        if (pop_ok) begin
            if (count > CNT_W'(1)) begin
                head_nxt_c = mem_q[f_inc(rd_ptr)];
            end
        end else if (!empty_c) begin
            head_nxt_c = mem_q[rd_ptr];
        end
    end

    // Pointers and occupancy
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= f_inc(wr_ptr);
            if (pop_ok)  rd_ptr <= f_inc(rd_ptr);
            count <= count_nxt;
        end
    end

    // Entry storage; validity is tracked by count alone
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr] <= wdata;
        end
    end

endmodule

// File: rtl/vid_fetch_agen.sv
// Captures displayed CRTC characters, composes their VRAM byte address and
// issues BURST read beats per character to the VRAM arbiter.
//   clk, rst       : clock, synchronous active-high reset
//   char_stb, de   : character strobe and display enable from the CRTC
//   crtc_ma/ra     : CRTC memory / row address
//   mode           : addressing mode (vid_amode_e)
//   page_reg       : upper address bits, captured with each character
//   flush          : abort all pending fetches
//   mem            : read-request bus (req/addr/idx/last out, ack in)
//   busy           : queue non-empty
//   overrun        : sticky, a character was dropped; ovr_clr clears it
module vid_fetch_agen
    import vid_pkg::*;
#(
    parameter int unsigned ADDR_W = 24,
    parameter int unsigned BURST  = 2,
    parameter int unsigned QDEPTH = 2,
    parameter int unsigned IDX_W  = (BURST > 1) ? $clog2(BURST) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 char_stb,
    input  logic                 de,
    input  logic [13:0]          crtc_ma,
    input  logic [4:0]           crtc_ra,
    input  logic [1:0]           mode,
    input  logic [ADDR_W-17:0]   page_reg,
    input  logic                 flush,
    vid_fetch_agen_if.master     mem,
    output logic                 busy,
    output logic                 overrun,
    input  logic                 ovr_clr
);

    localparam int unsigned PAGE_W = ADDR_W - 16;
    localparam int unsigned ENT_W  = PAGE_W + OFF_W;
    localparam int unsigned CNT_W  = $clog2(QDEPTH + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BURST - 1);

    vid_state_e        state_q;
    vid_state_e        state_nxt;
    logic [IDX_W-1:0]  idx_q;
    logic [IDX_W-1:0]  idx_nxt;
    logic              req_q;
    logic              last_q;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] addr_nxt;

    logic [ENT_W-1:0]  wdata;
    logic [ENT_W-1:0]  head_nxt_c;
    logic              empty_nxt_c;
    logic              full_c;
    logic              empty_c;
    logic [CNT_W-1:0]  q_count;

    logic              beat_last_c;
    logic              push_req_c;
    logic              push_c;
    logic              pop_c;
    logic              ovr_set_c;
    logic              unused_ra_c;

    assign unused_ra_c = ^crtc_ra[4:3];

    // Queue entry: base page plus in-page offset, frozen at capture time
    assign wdata = {page_reg, f_vid_offset(crtc_ma, crtc_ra[2:0], vid_amode_e'(mode))};

    assign beat_last_c = (idx_q == LAST_IDX);
    assign pop_c       = (state_q == ST_ISSUE) & mem.ack & beat_last_c & ~flush;
    assign push_req_c  = char_stb & de & ~flush;
    assign push_c      = push_req_c & (~full_c | pop_c);
    assign ovr_set_c   = push_req_c & full_c & ~pop_c;

    vid_fetch_q #(
        .W     (ENT_W),
        .DEPTH (QDEPTH),
        .CNT_W (CNT_W)
    ) u_q (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .push        (push_c),
        .pop         (pop_c),
        .wdata       (wdata),
        .head_nxt_c  (head_nxt_c),
        .empty_nxt_c (empty_nxt_c),
        .full_c      (full_c),
        .empty_c     (empty_c),
        .count       (q_count)
    );

    // Next state, beat index and beat address
    always_comb begin
        state_nxt = state_q;
        idx_nxt   = idx_q;
        if (flush) begin
            state_nxt = ST_IDLE;
            idx_nxt   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (!empty_c || push_c) begin
                        state_nxt = ST_ISSUE;
                        idx_nxt   = '0;
                    end
                end
                ST_ISSUE: begin
                    if (mem.ack) begin
                        if (beat_last_c) begin
                            idx_nxt = '0;
                            if (empty_nxt_c) state_nxt = ST_IDLE;
                        end else begin
                            idx_nxt = idx_q + IDX_W'(1);
                        end
                    end
                end
                default: begin
                    state_nxt = ST_IDLE;
                    idx_nxt   = '0;
                end
            endcase
        end
        // Carry out of the offset is discarded so beats wrap inside the page
        addr_nxt = {head_nxt_c[ENT_W-1:OFF_W],
                    OFF_W'(head_nxt_c[OFF_W-1:0] + OFF_W'(idx_nxt))};
    end

    // State and registered bus outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            req_q   <= 1'b0;
            last_q  <= 1'b0;
            addr_q  <= '0;
        end else begin
            state_q <= state_nxt;
            idx_q   <= idx_nxt;
            req_q   <= (state_nxt == ST_ISSUE);
            last_q  <= (state_nxt == ST_ISSUE) && (idx_nxt == LAST_IDX);
            addr_q  <= (state_nxt == ST_ISSUE) ? addr_nxt : '0;
        end
    end

    // Sticky overrun; a new drop wins over a same-cycle clear
    always_ff @(posedge clk) begin
        if (rst) begin
            overrun <= 1'b0;
        end else if (ovr_set_c) begin
            overrun <= 1'b1;
        end else if (ovr_clr) begin
            overrun <= 1'b0;
        end
    end

    assign mem.req  = req_q;
    assign mem.addr = addr_q;
    assign mem.idx  = idx_q;
    assign mem.last = last_q;
    assign busy     = (q_count != '0);

endmodule
